uart_tx_fifo: RTL

//  Transmit stage that sits directly upstream of FPGA_top's serial output tx_data.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter, LSB first, no idle gap between queued frames.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              tx_busy,
    output logic              tx_data
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_n;
    logic [BW-1:0]     baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shift_reg, shift_n;
    logic              tx_q, tx_n;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push, pop, baud_done;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_n;
`endif

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign tx_busy    = (state != IDLE);
    assign tx_data    = tx_q;
    assign push       = wr_en && !full;
    assign baud_done  = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        tx_n    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        if (state != IDLE)
            baud_n = baud_done ? '0 : baud_cnt + BW'(1);
        case (state)
            IDLE:  pop = !empty;
            START: if (baud_done) begin
                tx_n    = shift_reg[0];
                state_n = DATA;
            end
            DATA: if (baud_done) begin
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    tx_n    = par_q;
                    state_n = PARITY;
`else
                    tx_n    = 1'b1;
                    state_n = STOP;
`endif
                end else begin
                    shift_n = {1'b0, shift_reg[7:1]};
                    tx_n    = shift_reg[1];
                    bit_n   = bit_cnt + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_done) begin
                tx_n    = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (baud_done) begin
                pop     = !empty;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // a pop always launches a start bit, from IDLE or straight out of STOP
        if (pop) begin
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            bit_n   = '0;
            baud_n  = '0;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            tx_q      <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_n;
`endif
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && !pop)
                count <= count + (ADDR_W + 1)'(1);
            else if (pop && !push)
                count <= count - (ADDR_W + 1)'(1);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule
